vga_sync_decoder: RTL and testbench

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

---
 rtl/vga_timing_pkg.sv | 25 ++
 rtl/sync_edge_detect.sv | 30 +++
 rtl/vga_sync_decoder.sv | 157 +++++++++++++++
 tb/tb_vga_sync_decoder.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults, sync FSM state encoding and counter helper.
package vga_timing_pkg;

  // 640x480 @ 60 Hz, 25 MHz pixel clock
  localparam int unsigned DEF_H_VISIBLE = 640;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BACK    = 48;
  localparam int unsigned DEF_H_TOTAL   = 800;
  localparam int unsigned DEF_V_VISIBLE = 480;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BACK    = 33;
  localparam int unsigned DEF_V_TOTAL   = 525;

  typedef enum logic [1:0] {
    StSearch = 2'd0,
    StTrain  = 2'd1,
    StLocked = 2'd2
  } sync_state_e;

  // 10-bit increment that sticks at all-ones
  function automatic logic [9:0] sat_inc10(input logic [9:0] val);
    return (val == 10'h3FF) ? val : val + 10'd1;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Registers one sync input and flags rising/falling edges against the previous sample.
module sync_edge_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic din_i,
  output logic rise_o,
  output logic fall_o
);

  logic sample_q;
  logic prev_q;

  // Sync lines idle high, so both stages reset to 1 to avoid a spurious edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sample_q <= 1'b1;
      prev_q   <= 1'b1;
    end else begin
      sample_q <= din_i;
      prev_q   <= sample_q;
    end
  end

  // Edge pulses are combinational from the two registered samples.
  always_comb begin
    rise_o = sample_q & ~prev_q;
    fall_o = prev_q & ~sample_q;
  end

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates from an incoming VGA stream, checks its timing and
// locks after one clean training frame.
module vga_sync_decoder
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BACK    = DEF_H_BACK,
  parameter int unsigned H_TOTAL   = DEF_H_TOTAL,
  parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BACK    = DEF_V_BACK,
  parameter int unsigned V_TOTAL   = DEF_V_TOTAL
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       redIn,
  input  logic       greenIn,
  input  logic       blueIn,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic [2:0] pix_rgb,
  output logic       pix_valid,
  output logic       frame_done,
  output logic       locked,
  output logic       timing_error,
  output logic [7:0] err_cnt
);

  localparam logic [9:0] HActStart = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] HActEnd   = 10'(H_SYNC + H_BACK + H_VISIBLE - 1);
  localparam logic [9:0] VActStart = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] VActEnd   = 10'(V_SYNC + V_BACK + V_VISIBLE - 1);
  localparam logic [9:0] HLast     = 10'(H_TOTAL - 1);
  localparam logic [9:0] VLast     = 10'(V_TOTAL - 1);
  localparam logic [9:0] HSyncEnd  = 10'(H_SYNC);
  localparam logic [9:0] VSyncEnd  = 10'(V_SYNC);
  localparam logic [9:0] CntMax    = 10'h3FF;

  logic        hs_rise, hs_fall, vs_rise, vs_fall;
  logic [2:0]  rgb_q;
  logic [9:0]  h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  sync_state_e state_q, state_d;
  logic        chk_fail;
  logic        active;
  logic        pix_hit;
  logic        frame_hit;

  sync_edge_detect u_hs_edge (
    .clk_i  (vga_clk),
    .rst_i  (reset),
    .din_i  (hsync),
    .rise_o (hs_rise),
    .fall_o (hs_fall)
  );

  sync_edge_detect u_vs_edge (
    .clk_i  (vga_clk),
    .rst_i  (reset),
    .din_i  (vsync),
    .rise_o (vs_rise),
    .fall_o (vs_fall)
  );

  // Colour is sampled alongside the syncs so it stays aligned with the counters.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      rgb_q <= 3'b000;
    end else begin
      rgb_q <= {redIn, greenIn, blueIn};
    end
  end

  // Counter next state: the counts assigned to the sample now in the input register.
  always_comb begin
    h_cnt_d = hs_fall ? 10'd0 : sat_inc10(h_cnt_q);
    if (vs_fall) begin
      v_cnt_d = 10'd0;
    end else if (hs_fall) begin
      v_cnt_d = sat_inc10(v_cnt_q);
    end else begin
      v_cnt_d = v_cnt_q;
    end
  end

  // Timing checks: falls compare the count that ended, rises the count just assigned.
  always_comb begin
    chk_fail = 1'b0;
    if (state_q != StSearch) begin
      chk_fail = (hs_fall && (h_cnt_q != HLast))
              || (hs_rise && (h_cnt_d != HSyncEnd))
              || (vs_fall && (v_cnt_q != VLast))
              || (vs_rise && (v_cnt_d != VSyncEnd))
              || ((h_cnt_d == CntMax) && (h_cnt_q != CntMax));
    end
  end

  // Lock FSM next state; an error always wins over a vsync fall.
  always_comb begin
    state_d = state_q;
    if (chk_fail) begin
      state_d = StSearch;
    end else if (vs_fall) begin
      unique case (state_q)
        StSearch: state_d = StTrain;
        StTrain:  state_d = StLocked;
        StLocked: state_d = StLocked;
        default:  state_d = StSearch;
      endcase
    end
  end

  // Active-area decode and pulse qualifiers for the registered outputs.
  always_comb begin
    active = (h_cnt_d >= HActStart) && (h_cnt_d <= HActEnd)
          && (v_cnt_d >= VActStart) && (v_cnt_d <= VActEnd);
    pix_hit   = active && (state_d == StLocked);
    frame_hit = vs_fall && (state_q == StLocked) && !chk_fail;
  end

  // State, counters and all outputs; pixel fields hold outside valid pixels.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      state_q      <= StSearch;
      h_cnt_q      <= 10'd0;
      v_cnt_q      <= 10'd0;
      pix_x        <= 10'd0;
      pix_y        <= 10'd0;
      pix_rgb      <= 3'b000;
      pix_valid    <= 1'b0;
      frame_done   <= 1'b0;
      locked       <= 1'b0;
      timing_error <= 1'b0;
      err_cnt      <= 8'd0;
    end else begin
      state_q      <= state_d;
      h_cnt_q      <= h_cnt_d;
      v_cnt_q      <= v_cnt_d;
      pix_valid    <= pix_hit;
      frame_done   <= frame_hit;
      locked       <= (state_d == StLocked);
      timing_error <= chk_fail;
      if (chk_fail && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
      if (pix_hit) begin
        pix_x   <= h_cnt_d - HActStart;
        pix_y   <= v_cnt_d - VActStart;
        pix_rgb <= rgb_q;
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Self-checking bench for vga_sync_decoder using a reduced frame geometry.
module tb_vga_sync_decoder;

  localparam int HV  = 16;
  localparam int HS  = 4;
  localparam int HB  = 3;
  localparam int HT  = 28;
  localparam int VV  = 8;
  localparam int VS  = 2;
  localparam int VB  = 3;
  localparam int VT  = 16;
  localparam int HA0 = HS + HB;
  localparam int VA0 = VS + VB;

  logic       vga_clk = 1'b0;
  logic       reset   = 1'b1;
  logic       hsync   = 1'b1;
  logic       vsync   = 1'b1;
  logic       redIn   = 1'b0;
  logic       greenIn = 1'b0;
  logic       blueIn  = 1'b0;
  logic [9:0] pix_x, pix_y;
  logic [2:0] pix_rgb;
  logic       pix_valid, frame_done, locked, timing_error;
  logic [7:0] err_cnt;

  vga_sync_decoder #(
    .H_VISIBLE (HV),
    .H_SYNC    (HS),
    .H_BACK    (HB),
    .H_TOTAL   (HT),
    .V_VISIBLE (VV),
    .V_SYNC    (VS),
    .V_BACK    (VB),
    .V_TOTAL   (VT)
  ) dut (
    .vga_clk      (vga_clk),
    .reset        (reset),
    .hsync        (hsync),
    .vsync        (vsync),
    .redIn        (redIn),
    .greenIn      (greenIn),
    .blueIn       (blueIn),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .pix_rgb      (pix_rgb),
    .pix_valid    (pix_valid),
    .frame_done   (frame_done),
    .locked       (locked),
    .timing_error (timing_error),
    .err_cnt      (err_cnt)
  );

  always #5 vga_clk = ~vga_clk;

  typedef struct {
    bit         chk;
    bit         valid;
    bit         lock;
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] rgb;
  } sb_item_t;

  sb_item_t   sb_q[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         valid_seen, fd_seen, te_seen, fd_idx, te_idx, lock_idx;
  logic       prev_locked = 1'b0;
  logic [9:0] hx = '0;
  logic [9:0] hy = '0;
  logic [2:0] hrgb = '0;
  int         fall[12];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clear_counts();
    valid_seen = 0;
    fd_seen    = 0;
    te_seen    = 0;
    fd_idx     = -1;
    te_idx     = -1;
    lock_idx   = -1;
  endtask

  // Event indices are recorded as the drive cycle whose sample caused them.
  task automatic observe();
    sb_item_t e;
    int       obs;
    obs = cyc - 2;
    if (sb_q.size() == 2) begin
      e = sb_q.pop_front();
      if (e.chk) begin
        check_eq("pix_valid", {31'd0, pix_valid}, {31'd0, e.valid});
        check_eq("locked", {31'd0, locked}, {31'd0, e.lock});
        check_eq("pix_x", {22'd0, pix_x}, {22'd0, e.x});
        check_eq("pix_y", {22'd0, pix_y}, {22'd0, e.y});
        check_eq("pix_rgb", {29'd0, pix_rgb}, {29'd0, e.rgb});
      end
    end
    if (pix_valid) valid_seen++;
    if (frame_done) begin
      fd_seen++;
      fd_idx = obs;
    end
    if (timing_error) begin
      te_seen++;
      te_idx = obs;
    end
    if (locked && !prev_locked) lock_idx = obs;
    prev_locked = locked;
  endtask

  task automatic step(input logic hs, input logic vs, input logic [2:0] rgb, input sb_item_t it);
    @(negedge vga_clk);
    observe();
    hsync   = hs;
    vsync   = vs;
    redIn   = rgb[2];
    greenIn = rgb[1];
    blueIn  = rgb[0];
    sb_q.push_back(it);
    cyc++;
  endtask

  function automatic logic [2:0] pat(input int h, input int v);
    if (h == HA0 + HV - 1 && v == VA0 + VV - 1) return 3'b101;
    return 3'((h * 3 + v * 5) % 7);
  endfunction

  // One frame; long_line gets HT+1 clocks, stuck_line keeps hsync high for 1100
  // clocks, stop_line aborts the frame. exp_lock is the lock state expected for it.
  task automatic send_frame(input bit exp_lock, input int long_line, input int stuck_line,
                            input int stop_line, output int fall_idx);
    int         len;
    bit         lk, act, hs;
    logic [2:0] rgb;
    sb_item_t   it;
    fall_idx = cyc;
    for (int v = 0; v < VT; v++) begin
      if (v == stop_line) return;
      len = (v == long_line) ? HT + 1 : (v == stuck_line) ? 1100 : HT;
      lk  = exp_lock && !(long_line >= 0 && v > long_line)
                     && !(stuck_line >= 0 && v > stuck_line);
      for (int h = 0; h < len; h++) begin
        hs  = (v == stuck_line) ? 1'b1 : (h >= HS);
        rgb = pat(h, v);
        act = (h >= HA0) && (h < HA0 + HV) && (v >= VA0) && (v < VA0 + VV);
        if (lk && act) begin
          hx   = 10'(h - HA0);
          hy   = 10'(v - VA0);
          hrgb = rgb;
        end
        it.chk   = (h == HA0 && v == VA0) || (h == HA0 + HV - 1 && v == VA0 + VV - 1)
                || (h == HA0 + HV && v == VA0);
        it.valid = lk && act;
        it.lock  = lk;
        it.x     = hx;
        it.y     = hy;
        it.rgb   = hrgb;
        step(hs, (v >= VS), rgb, it);
      end
    end
  endtask

  task automatic check_rst_outputs(input string tag);
    check_eq({tag, "_pix_x"}, {22'd0, pix_x}, 32'd0);
    check_eq({tag, "_pix_y"}, {22'd0, pix_y}, 32'd0);
    check_eq({tag, "_pix_rgb"}, {29'd0, pix_rgb}, 32'd0);
    check_eq({tag, "_pix_valid"}, {31'd0, pix_valid}, 32'd0);
    check_eq({tag, "_frame_done"}, {31'd0, frame_done}, 32'd0);
    check_eq({tag, "_locked"}, {31'd0, locked}, 32'd0);
    check_eq({tag, "_timing_error"}, {31'd0, timing_error}, 32'd0);
    check_eq({tag, "_err_cnt"}, {24'd0, err_cnt}, 32'd0);
  endtask

  task automatic release_reset();
    sb_q.delete();
    hx          = '0;
    hy          = '0;
    hrgb        = '0;
    prev_locked = 1'b0;
    @(negedge vga_clk);
    reset = 1'b0;
  endtask

  initial begin
    sb_item_t idle;
    idle = '{chk: 1'b0, valid: 1'b0, lock: 1'b0, x: '0, y: '0, rgb: '0};

    repeat (2) @(negedge vga_clk);
    check_rst_outputs("rst");
    release_reset();

    // Ideal stream: train, lock at 2nd fall, first frame_done at 3rd fall
    clear_counts();
    send_frame(1'b0, -1, -1, -1, fall[0]);
    send_frame(1'b1, -1, -1, -1, fall[1]);
    send_frame(1'b1, -1, -1, -1, fall[2]);
    check_eq("a_valid_cnt", valid_seen, 2 * HV * VV);
    check_eq("a_lock_idx", lock_idx, fall[1]);
    check_eq("a_fd_cnt", fd_seen, 1);
    check_eq("a_fd_idx", fd_idx, fall[2]);
    check_eq("a_te_cnt", te_seen, 0);
    check_eq("a_err_cnt", {24'd0, err_cnt}, 32'd0);

    // One line of HT+1 clocks while locked: error at the next hsync fall
    clear_counts();
    send_frame(1'b1, 6, -1, -1, fall[3]);
    send_frame(1'b0, -1, -1, -1, fall[4]);
    send_frame(1'b1, -1, -1, -1, fall[5]);
    check_eq("b_te_cnt", te_seen, 1);
    check_eq("b_te_idx", te_idx, fall[3] + 7 * HT + 1);
    check_eq("b_err_cnt", {24'd0, err_cnt}, 32'd1);
    check_eq("b_valid_cnt", valid_seen, 2 * HV + HV * VV);
    check_eq("b_lock_idx", lock_idx, fall[5]);
    check_eq("b_fd_cnt", fd_seen, 1);
    check_eq("b_fd_idx", fd_idx, fall[3]);
    check_eq("b_locked", {31'd0, locked}, 32'd1);

    // hsync stuck high: error when h_cnt reaches 1023
    clear_counts();
    send_frame(1'b1, -1, 4, -1, fall[6]);
    send_frame(1'b0, -1, -1, -1, fall[7]);
    send_frame(1'b1, -1, -1, -1, fall[8]);
    check_eq("c_te_cnt", te_seen, 1);
    check_eq("c_te_idx", te_idx, fall[6] + 4 * HT + (1023 - HT));
    check_eq("c_err_cnt", {24'd0, err_cnt}, 32'd2);
    check_eq("c_valid_cnt", valid_seen, HV * VV);
    check_eq("c_lock_idx", lock_idx, fall[8]);
    check_eq("c_fd_cnt", fd_seen, 1);
    check_eq("c_fd_idx", fd_idx, fall[6]);

    // Reset mid-frame while locked: outputs clear at once, full retrain needed
    clear_counts();
    send_frame(1'b1, -1, -1, 6, fall[9]);
    check_eq("d_locked_pre", {31'd0, locked}, 32'd1);
    check_eq("d_fd_idx", fd_idx, fall[9]);
    #2;
    reset = 1'b1;
    hsync = 1'b1;
    vsync = 1'b1;
    #1;
    check_rst_outputs("d_rst");
    repeat (2) @(negedge vga_clk);
    release_reset();
    clear_counts();
    send_frame(1'b0, -1, -1, -1, fall[10]);
    send_frame(1'b1, -1, -1, -1, fall[11]);
    check_eq("d_lock_idx", lock_idx, fall[11]);
    check_eq("d_err_cnt", {24'd0, err_cnt}, 32'd0);
    check_eq("d_te_cnt", te_seen, 0);
    check_eq("d_valid_cnt", valid_seen, HV * VV);
    check_eq("d_fd_cnt", fd_seen, 0);

    // 300 errors: vsync fall enters TRAIN, early vsync rise fails the check
    @(negedge vga_clk);
    reset = 1'b1;
    hsync = 1'b1;
    vsync = 1'b1;
    repeat (2) @(negedge vga_clk);
    release_reset();
    clear_counts();
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 1'b0, 3'b000, idle);
      step(1'b1, 1'b1, 3'b000, idle);
    end
    repeat (3) step(1'b1, 1'b1, 3'b000, idle);
    check_eq("e_te_cnt", te_seen, 300);
    check_eq("e_err_cnt", {24'd0, err_cnt}, 32'd255);
    check_eq("e_locked", {31'd0, locked}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
